// File: rtl/neuron_mac_accumulator.sv
// Single-neuron dot-product engine: bias plus LEN signed act*wt products in a guard accumulator,
// saturated to 32-bit signed and presented as a one-cycle pulse to the activation stage.
//
// state  | meaning
// IDLE   | waiting for start; bias and len captured on start
// ACCUM  | accepting act/wt pairs, in_ready high, cnt counts down to 1
// DONE   | one cycle; saturated sum registered onto out_data with valid_out
module neuron_mac_accumulator #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 10,
  parameter int ACC_W  = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [31:0]       bias,
  input  logic [DATA_W-1:0] act_in,
  input  logic [DATA_W-1:0] wt_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       out_data,
  output logic              valid_out,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [31:0]              out_data_q, out_data_d;
  logic                     valid_out_q, valid_out_d;
  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;

  logic signed [2*DATA_W-1:0] act_ext, wt_ext, prod;
  logic signed [ACC_W-1:0]    prod_ext, bias_ext;
  logic [ACC_W-32:0]          acc_upper;
  logic [31:0]                sat_val;
  logic                       beat;

  // Operands widened first so the multiply is a full-width signed product.
  assign act_ext  = {{DATA_W{act_in[DATA_W-1]}}, act_in};
  assign wt_ext   = {{DATA_W{wt_in[DATA_W-1]}}, wt_in};
  assign prod     = act_ext * wt_ext;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-32){bias[31]}}, bias};

  // Sum fits in 32 bits only when bits [ACC_W-1:31] are all copies of the sign.
  assign acc_upper = acc_q[ACC_W-1:31];
  always_comb begin
    if ((&acc_upper) || !(|acc_upper)) sat_val = acc_q[31:0];
    else if (acc_q[ACC_W-1])           sat_val = 32'h8000_0000;
    else                               sat_val = 32'h7FFF_FFFF;
  end

  assign beat = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    valid_out_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = bias_ext;
          cnt_d   = len;
          state_d = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (beat) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_data_d  = sat_val;
        valid_out_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_ACCUM);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      valid_out_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      valid_out_q <= valid_out_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign valid_out = valid_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Randomized bench for neuron_mac_accumulator, checked against an arithmetic model of
// bias + sum(act*wt) with 32-bit saturation and the documented handshake timing.
module tb_neuron_mac_accumulator;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 10;
  localparam int ACC_W  = 48;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [31:0]       bias;
  logic [DATA_W-1:0] act_in;
  logic [DATA_W-1:0] wt_in;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       out_data;
  logic              valid_out;
  logic              busy;

  neuron_mac_accumulator #(.DATA_W(DATA_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
    .act_in(act_in), .wt_in(wt_in), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int act_q[$];
  int wt_q[$];
  bit vpat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input int b);
    longint s;
    s = longint'(b);
    foreach (act_q[i]) s += longint'(act_q[i]) * longint'(wt_q[i]);
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  function automatic int rand_op(input int mode);
    logic signed [15:0] t;
    case (mode)
      0:       t = 16'($urandom);
      1:       t = 16'($urandom_range(0, 15)) - 16'sd8;
      default: t = $urandom_range(0, 1) ? 16'sh7FFF : 16'sh8000;
    endcase
    return int'(t);
  endfunction

  task automatic fill_pairs(input int n, input int mode);
    act_q.delete();
    wt_q.delete();
    for (int i = 0; i < n; i++) begin
      act_q.push_back(rand_op(mode));
      wt_q.push_back(rand_op(mode));
    end
  endtask

  task automatic load_sc1();
    act_q = '{2, -4, 7};
    wt_q  = '{3, 5, 1};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one evaluation at the current cycle and returns in the cycle valid_out is high.
  task automatic run_eval(input string tag, input int b, input bit stall_en, input bit mid_start);
    logic [31:0] exp;
    int n;
    int accepted;
    int cyc;
    int a_tmp;
    int w_tmp;
    bit v;
    exp = ref_result(b);
    n = act_q.size();
    accepted = 0;
    cyc = 0;
    start = 1'b1;
    len = LEN_W'(n);
    bias = b;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    chk({tag, "_valid_after_start"}, 32'(valid_out), 0);
    chk({tag, "_busy_after_start"}, 32'(busy), 1);
    while (accepted < n) begin
      if (vpat.size() > 0) v = vpat.pop_front();
      else v = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      chk({tag, "_in_ready_accum"}, 32'(in_ready), 1);
      a_tmp = act_q[accepted];
      w_tmp = wt_q[accepted];
      in_valid = v;
      act_in = v ? a_tmp[DATA_W-1:0] : DATA_W'($urandom);
      wt_in  = v ? w_tmp[DATA_W-1:0] : DATA_W'($urandom);
      if (mid_start && cyc == 2) begin
        start = 1'b1;
        len = LEN_W'(1);
        bias = 32'd99;
      end
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      if (v) accepted++;
      cyc++;
    end
    chk({tag, "_done_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_done_busy"}, 32'(busy), 1);
    chk({tag, "_done_valid"}, 32'(valid_out), 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid_out"}, 32'(valid_out), 1);
    chk({tag, "_out_data"}, out_data, exp);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_in_ready_after"}, 32'(in_ready), 0);
  endtask

  task automatic idle_after(input string tag, input logic [31:0] hold_val);
    tick();
    chk({tag, "_valid_cleared"}, 32'(valid_out), 0);
    chk({tag, "_out_hold"}, out_data, hold_val);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    bias = '0;
    act_in = '0;
    wt_in = '0;
    in_valid = 1'b0;
    tick();
    tick();
    chk("reset_out_data", out_data, 0);
    chk("reset_valid", 32'(valid_out), 0);
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    load_sc1();
    run_eval("sc1", 10, 1'b0, 1'b0);
    chk("sc1_literal", out_data, 32'd3);
    idle_after("sc1", 32'd3);

    act_q.delete();
    wt_q.delete();
    run_eval("sc2", -5, 1'b0, 1'b0);
    chk("sc2_literal", out_data, 32'hFFFF_FFFB);
    idle_after("sc2", 32'hFFFF_FFFB);

    act_q = '{32767, 32767, 32767, 32767};
    wt_q  = '{32767, 32767, 32767, 32767};
    run_eval("sc3_pos", 32'h7FFF_0000, 1'b0, 1'b0);
    chk("sc3_pos_literal", out_data, 32'h7FFF_FFFF);
    idle_after("sc3_pos", 32'h7FFF_FFFF);
    act_q = '{-32768, -32768};
    wt_q  = '{32767, 32767};
    run_eval("sc3_neg", int'(32'h8000_0000), 1'b0, 1'b0);
    chk("sc3_neg_literal", out_data, 32'h8000_0000);
    idle_after("sc3_neg", 32'h8000_0000);

    load_sc1();
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_eval("sc4", 10, 1'b0, 1'b1);
    chk("sc4_literal", out_data, 32'd3);
    idle_after("sc4", 32'd3);
    repeat (3) begin
      tick();
      chk("sc4_no_second_pulse", 32'(valid_out), 0);
    end

    start = 1'b1;
    len = LEN_W'(5);
    bias = 32'd7;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    act_in = 16'd100;
    wt_in = 16'd100;
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sc5_in_ready", 32'(in_ready), 0);
    chk("sc5_busy", 32'(busy), 0);
    chk("sc5_out_data", out_data, 0);
    chk("sc5_valid", 32'(valid_out), 0);
    in_valid = 1'b1;
    repeat (6) begin
      tick();
      chk("sc5_no_pulse", 32'(valid_out), 0);
      chk("sc5_stays_idle", 32'(busy), 0);
    end
    in_valid = 1'b0;
    load_sc1();
    run_eval("sc5_rerun", 10, 1'b0, 1'b0);
    chk("sc5_rerun_literal", out_data, 32'd3);

    act_q = '{-3};
    wt_q  = '{2};
    run_eval("sc6", 1, 1'b0, 1'b0);
    chk("sc6_literal", out_data, 32'hFFFF_FFFB);
    idle_after("sc6", 32'hFFFF_FFFB);

    act_q = '{};
    wt_q  = '{};
    fill_pairs(1023, 2);
    foreach (act_q[i]) begin
      act_q[i] = -32768;
      wt_q[i] = -32768;
    end
    run_eval("long_pos", 0, 1'b0, 1'b0);
    fill_pairs(1023, 2);
    foreach (act_q[i]) begin
      act_q[i] = -32768;
      wt_q[i] = 32767;
    end
    run_eval("long_neg", int'($urandom), 1'b1, 1'b0);
    idle_after("long_neg", 32'h8000_0000);

    for (int k = 0; k < 60; k++) begin
      int mode;
      int n;
      logic [31:0] last;
      mode = int'($urandom_range(0, 2));
      n = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
      fill_pairs(n, mode);
      run_eval("rand", (mode == 2) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000,
               1'(($urandom_range(0, 1))), 1'b0);
      last = ref_result((mode == 2) ? 0 : 0);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk("rand_valid_cleared", 32'(valid_out), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/neuron_mac_accumulator.md
Name: neuron_mac_accumulator

Overview:
Single-neuron dot-product engine that sits directly upstream of the ReLU activation stage.
- Takes one bias and a stream of LEN signed activation/weight pairs.
- Multiply-accumulates them in a wide guard accumulator, then saturates the sum to 32-bit signed.
- Emits the sum as a one-cycle out_data/valid_out pulse, which wires straight into the activation stage's in_data/valid_in.

Parameters:
DATA_W, 16, width of signed activation and weight operands
LEN_W, 10, width of the length field; max vector length 2^LEN_W-1
ACC_W, 48, internal accumulator width; must be >= 2*DATA_W+LEN_W+1 and >= 33

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a new neuron evaluation (sampled only in IDLE)
len  input  LEN_W  number of pairs for this evaluation, sampled with start
bias  input  32  signed bias, sampled with start
act_in  input  DATA_W  signed activation operand
wt_in  input  DATA_W  signed weight operand
in_valid  input  1  act_in/wt_in valid
in_ready  output  1  block accepts a pair this cycle
out_data  output  32  saturated signed dot product plus bias
valid_out  output  1  one-cycle pulse, out_data valid
busy  output  1  high in ACCUM and DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, acc=0, cnt=0, out_data=0, valid_out=0, in_ready=0, busy=0.
- Reset mid-operation: the partial sum is discarded. All outputs return to reset values on that edge. No valid_out is produced for the aborted evaluation.
- FSM states: IDLE, ACCUM, DONE. in_ready=1 only in ACCUM. busy=1 in ACCUM and DONE.
- IDLE, start=1, len>0: acc <= sign-extend(bias) to ACC_W; cnt <= len; next state ACCUM.
- IDLE, start=1, len==0: acc <= sign-extend(bias); next state DONE (bias-only result).
- ACCUM: a beat is accepted when in_valid && in_ready.
  - On an accepted beat: acc <= acc + sign-extend($signed(act_in)*$signed(wt_in)); cnt <= cnt-1.
  - If the accepted beat has cnt==1, next state is DONE.
  - in_valid low means a stall: acc and cnt hold. Gaps of any length are legal.
- DONE (exactly one cycle): at the end of this cycle, out_data <= sat32(acc), valid_out <= 1, state <= IDLE.
- sat32 rule:
  - acc > 2^31-1 gives 0x7FFFFFFF.
  - acc < -2^31 gives 0x80000000.
  - Otherwise acc[31:0].
- valid_out is high for exactly one cycle and is cleared on the following edge.
- out_data holds its last value until the next result.
- Latency:
  - The last accepted beat is at edge N. State is DONE during cycle N..N+1. valid_out is high from edge N+1 to N+2.
  - For len==0, a start sampled at edge S gives valid_out high from S+1 to S+2.
- start in ACCUM or DONE is ignored, with no effect on acc, cnt or len. in_valid outside ACCUM is ignored.
- A new start may be sampled in the same cycle valid_out is high, because state is IDLE then.
- Product width is 2*DATA_W signed; sign extension is mandatory for every operand and for bias.
- No intermediate saturation: the guard bits guarantee no wrap for len <= 2^LEN_W-1. Saturation is applied only at output.

Test Plan:
1. Basic dot product:
   - Stimulus: rst 2 cycles, then start with bias=10, len=3; pairs (2,3), (-4,5), (7,1) on back-to-back cycles.
   - Required: out_data=3 (0x00000003); valid_out high exactly one cycle, on the 2nd rising edge after the last accepted beat; busy low afterwards.
2. Bias-only evaluation:
   - Stimulus: start with len=0, bias=-5.
   - Required: in_ready never rises; out_data=0xFFFFFFFB; valid_out pulses on the 2nd edge after start.
3. Saturation:
   - Positive case: bias=0x7FFF0000, len=4, each pair (32767,32767). Required: out_data=0x7FFFFFFF.
   - Negative case: bias=0x80000000, len=2, each pair (-32768,32767). Required: out_data=0x80000000.
4. Stalls and ignored start:
   - Stimulus: repeat scenario 1 with in_valid toggling 1,0,0,1,0,1, and a start pulse with bias=99, len=1 asserted mid-ACCUM.
   - Required: the result is still 3 and exactly one valid_out pulse occurs; the mid-run start has no effect.
5. Reset mid-accumulation:
   - Stimulus: start with len=5, feed 2 beats, then rst high for 1 cycle.
   - Required on the next edge: in_ready=0, busy=0, out_data=0, and no valid_out.
   - Then rerun scenario 1: result is 3.
6. Back-to-back evaluations:
   - Stimulus: issue the second start in the same cycle valid_out is high for the first evaluation.
   - Required: the second evaluation runs correctly (bias=1, len=1, pair (-3,2) gives out_data=0xFFFFFFFB).
